parity_push_stage: RTL
======================

# parity_push_stage

Upstream feeder for the parity-protected FIFO: accepts raw DATA_WIDTH-bit words from a producer, appends one parity bit per EVEN_ODD/PARITY_BIT, and drives the FIFO push interface. A two-entry skid buffer decouples producer and FIFO so full throughput holds under backpressure with a registered grant. Output words match the FIFO's DATA_WIDTH+1 word format exactly.

## Interface
- DATA_WIDTH, 32, payload bits per word.
- EVEN_ODD, 0, 0 = even parity (total ones in the DATA_WIDTH+1 word even), 1 = odd.
- PARITY_BIT, 0, 0 = parity in bit [DATA_WIDTH], payload in [DATA_WIDTH-1:0]; 1 = parity in bit 0, payload in [DATA_WIDTH:1].
- CNT_WIDTH, 16, width of the accepted-word counter.
- INJECT_PERIOD, 4, ERR_INJECT_EN only: every INJECT_PERIOD-th accepted word is a corruption candidate; must be ≥1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data_i  in  DATA_WIDTH  raw payload from producer.
- in_valid_i  in  1  producer has a word.
- in_grant_o  out  1  stage can accept a word (registered).
- push_data_o  out  DATA_WIDTH+1  payload plus parity to FIFO push_data_i.
- push_valid_o  out  1  word available, to FIFO push_valid_i.
- push_grant_i  in  1  FIFO accepts, from FIFO push_grant_o.
- word_cnt_o  out  CNT_WIDTH  accepted-word count, wraps.
- inj_en_i  in  1  ERR_INJECT_EN only: enable corruption.
- inj_cnt_o  out  CNT_WIDTH  ERR_INJECT_EN only: corrupted words emitted, wraps.

## Operation
- Accept: in_valid_i && in_grant_o at posedge. Emit: push_valid_o && push_grant_i at posedge.
- Parity = XOR-reduce(in_data_i) XOR EVEN_ODD, computed at acceptance; stored word is final DATA_WIDTH+1 format.
- Storage: main register (drives push_*) and skid register. States:
  - EMPTY: accept -> ONE (word to main).
  - ONE: accept & emit -> ONE (new word to main); accept only -> TWO (new word to skid); emit only -> EMPTY.
  - TWO: emit -> ONE (skid moves to main); no accept possible.
- in_grant_o next = (next state != TWO).
- Order strictly preserved; no word dropped or duplicated.
- word_cnt_o increments on each accept, wraps 2^CNT_WIDTH-1 -> 0.
- push_valid_o never drops without an emit; push_data_o stable while push_valid_o && !push_grant_i.

## Timing
- Reset values: push_valid_o=0, push_data_o=0, in_grant_o=0, word_cnt_o=0, inj_cnt_o=0, state EMPTY, both registers cleared.
- in_grant_o rises on the first posedge after rst deasserts.
- Latency: word accepted at edge N is on push_data_o with push_valid_o=1 after edge N (visible cycle N+1) when EMPTY.
- Throughput: one word/cycle with push_grant_i held high.
- Backpressure: after push_grant_i falls, at most two words are held; in_grant_o low from the edge that fills the skid register; rises the edge after first emit.
- Reset mid-operation: held words discarded immediately (async), all outputs to reset values.
- in_valid_i while in_grant_o=0: ignored, no state change.

## Configuration
- ERR_INJECT_EN defined: inj_en_i and inj_cnt_o exist; internal period counter advances on each accept; on the INJECT_PERIOD-th accept (counter wraps to 0) with inj_en_i=1, stored parity bit is inverted and inj_cnt_o increments. Period counter cleared by rst.
- ERR_INJECT_EN undefined: ports absent, parity always correct, no injection logic.

## Test plan
- DATA_WIDTH=32, EVEN_ODD=0, PARITY_BIT=0: in 0x0000_0001 -> push_data_o=0x1_0000_0001 one cycle later; in 0x0000_0003 -> 0x0_0000_0003.
- EVEN_ODD=1, PARITY_BIT=1: in 0x0000_0003 -> push_data_o=0x0_0000_0007.
- push_grant_i=0, in_valid_i=1 with 0xA,0xB,0xC -> 0xA,0xB accepted, in_grant_o=0, 0xC held by producer; push_grant_i=1 -> 0xA,0xB,0xC emitted in order on consecutive cycles, word_cnt_o=3.
- Two words held, rst pulse 3 ns mid-cycle -> push_valid_o=0 and word_cnt_o=0 immediately; in_grant_o=1 one edge after release; no held word emitted.
- Streaming 65536 words, CNT_WIDTH=16 -> word_cnt_o=0, no gaps with push_grant_i=1.
- ERR_INJECT_EN, INJECT_PERIOD=4, inj_en_i=1, words 1..8 -> words 4 and 8 carry inverted parity, others correct, inj_cnt_o=2.

Source files
------------

// File: rtl/parity_push_stage.sv
// Parity-appending push stage with a two-entry skid buffer feeding the parity-protected FIFO.
// Optional parity corruption for error-path testing is compiled in with `define ERR_INJECT_EN.
module parity_push_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int EVEN_ODD      = 0,
  parameter int PARITY_BIT    = 0,
  parameter int CNT_WIDTH     = 16,
  parameter int INJECT_PERIOD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_grant_o,
  output logic [DATA_WIDTH:0]   push_data_o,
  output logic                  push_valid_o,
  input  logic                  push_grant_i,
`ifdef ERR_INJECT_EN
  input  logic                  inj_en_i,
  output logic [CNT_WIDTH-1:0]  inj_cnt_o,
`endif
  output logic [CNT_WIDTH-1:0]  word_cnt_o
);

  localparam int WW = DATA_WIDTH + 1;

  if (INJECT_PERIOD < 1) begin : g_bad_period
    $error("INJECT_PERIOD must be at least 1");
  end

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t                state_q, state_d;
  logic [WW-1:0]         main_q, main_d;
  logic [WW-1:0]         skid_q, skid_d;
  logic                  grant_q, grant_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  accept, emit, flip;
  logic [WW-1:0]         new_word;

  function automatic logic [WW-1:0] pack_word(input logic [DATA_WIDTH-1:0] d, input logic inv);
    logic p;
    p = (^d) ^ logic'(EVEN_ODD != 0) ^ inv;
    if (PARITY_BIT == 0) return {p, d};
    else                 return {d, p};
  endfunction

  assign accept   = in_valid_i && grant_q;
  assign emit     = (state_q != EMPTY) && push_grant_i;
  assign new_word = pack_word(in_data_i, flip);

`ifdef ERR_INJECT_EN
  localparam int PW = (INJECT_PERIOD > 1) ? $clog2(INJECT_PERIOD) : 1;

  logic [PW-1:0]        per_q, per_d;
  logic [CNT_WIDTH-1:0] inj_q, inj_d;
  logic                 wrap;

  // The period counter marks every INJECT_PERIOD-th accepted word as a candidate.
  always_comb begin
    wrap  = (per_q == PW'(INJECT_PERIOD - 1));
    per_d = per_q;
    inj_d = inj_q;
    flip  = 1'b0;
    if (accept) begin
      per_d = wrap ? '0 : per_q + 1'b1;
      if (wrap && inj_en_i) begin
        flip  = 1'b1;
        inj_d = inj_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_q <= '0;
      inj_q <= '0;
    end else begin
      per_q <= per_d;
      inj_q <= inj_d;
    end
  end

  assign inj_cnt_o = inj_q;
`else
  assign flip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = new_word;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          main_d = new_word;
        end else if (accept) begin
          skid_d  = new_word;
          state_d = TWO;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (emit) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    cnt_d   = accept ? cnt_q + 1'b1 : cnt_q;
    // Grant is registered, so it looks ahead at the state being entered.
    grant_d = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      grant_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_grant_o   = grant_q;
  assign push_valid_o = (state_q != EMPTY);
  assign push_data_o  = main_q;
  assign word_cnt_o   = cnt_q;

endmodule
